// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO-to-stream reader: controller states and
// the depth of the output skid buffer.
package fifo_reader_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry, order-preserving skid buffer. The head entry drives m_data and
// m_valid straight from registers.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic [1:0]            occ
);

  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  m_valid_q, m_valid_d;
  logic                  pop;

  assign pop = m_valid_q && m_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
    m_valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= 2'd0;
      m_valid_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = head_q;
  assign m_valid = m_valid_q;
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Reads a synchronous FIFO with fixed one-cycle latency and forwards the words
// onto a valid/ready stream, with drain-on-disable and sticky underflow error.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  err_clr,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           word_cnt
);

  state_e      state_q, state_d;
  logic        inflight_q;
  logic        err_q, err_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  occ;
  logic        pop;
  logic        cap_ok;
  logic        cap_bad;
  logic [2:0]  committed;

  assign pop     = m_valid && m_ready;
  assign cap_ok  = inflight_q && !fifo_underflow;
  assign cap_bad = inflight_q && fifo_underflow;

  // Words already owed to the skid buffer once this cycle's pop is taken out.
  assign committed  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && (committed < 3'(SKID_DEPTH));

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    word_cnt_d = word_cnt_q + {15'd0, pop};

    if (cap_bad)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    if (cap_bad) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE:  if (en && !err_q) state_d = ST_RUN;
        ST_RUN:   if (!en) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (en)                              state_d = ST_RUN;
          else if (!inflight_q && occ == 2'd0) state_d = ST_IDLE;
        end
        ST_ERROR: if (err_clr) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  fifo_reader_skid #(
    .FIFO_WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (cap_ok),
    .push_data(fifo_data_out),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .occ      (occ)
  );

  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed bench for fifo_reader against a queue-based model of
// the source FIFO and of the words owed to the stream sink.
module tb_fifo_reader;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         err_clr = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         busy;
  logic         err;
  logic [15:0]  word_cnt;

  always #5 clk = ~clk;

  fifo_reader #(.FIFO_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .err_clr       (err_clr),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .err           (err),
    .word_cnt      (word_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic         pend_valid = 1'b0;
  logic         pend_uf = 1'b0;
  logic         inject_uf = 1'b0;
  logic [W-1:0] pend_word = '0;
  logic         err_m = 1'b0;
  logic [15:0]  cnt_m = 16'd0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           cyc = 0;
  int           n_rd = 0;
  int           n_xfer = 0;
  int           last_xfer_cyc = 0;
  int           gaps = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(W'($urandom));
    fifo_empty = (src_q.size() == 0);
  endtask

  // One clock cycle: observe just before the edge, then advance the model.
  task automatic step();
    logic         rd, xfer, cap;
    logic [W-1:0] d;
    #3;
    rd   = fifo_rd_en;
    xfer = m_valid && m_ready;
    d    = m_data;
    cap  = pend_valid;
    if (prev_hold) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    if (rd) chk("rd_when_empty", {31'd0, fifo_empty}, 32'd0);
    if (xfer) begin
      chk("xfer_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("m_data", {16'd0, d}, {16'd0, exp_q.pop_front()});
    end
    prev_hold = m_valid && !m_ready;
    prev_data = d;
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) begin
      cnt_m++;
      n_xfer++;
      if (n_xfer > 1 && cyc != last_xfer_cyc + 1) gaps++;
      last_xfer_cyc = cyc;
    end
    if (cap && pend_uf) err_m = 1'b1;
    else if (err_clr)   err_m = 1'b0;
    if (cap && !pend_uf) exp_q.push_back(pend_word);
    if (rd && src_q.size() != 0) begin
      pend_word      = src_q.pop_front();
      pend_valid     = 1'b1;
      pend_uf        = inject_uf;
      inject_uf      = 1'b0;
      fifo_data_out  = pend_word;
      fifo_underflow = pend_uf;
      n_rd++;
    end else begin
      pend_valid     = 1'b0;
      pend_uf        = 1'b0;
      fifo_underflow = 1'b0;
    end
    fifo_empty = (src_q.size() == 0);
    chk("word_cnt", {16'd0, word_cnt}, {16'd0, cnt_m});
    chk("err", {31'd0, err}, {31'd0, err_m});
    chk("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
    chk("skid_cap", {31'd0, exp_q.size() <= 2}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pend_valid     = 1'b0;
    pend_uf        = 1'b0;
    inject_uf      = 1'b0;
    fifo_underflow = 1'b0;
    cnt_m          = 16'd0;
    err_m          = 1'b0;
    prev_hold      = 1'b0;
    chk("rel_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0 && !pend_valid) break;
      step();
    end
    chk({tag, "_drained"}, {31'd0, src_q.size() == 0 && exp_q.size() == 0 && !pend_valid}, 32'd1);
  endtask

  initial begin
    int rd_at_drain;
    #1;
    do_reset();

    // Four preloaded words stream out back-to-back.
    en = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) src_q.push_back(W'(i));
    fifo_empty = 1'b0;
    n_xfer = 0; gaps = 0;
    drain("burst4", 20);
    chk("burst4_count", n_xfer, 4);
    chk("burst4_gaps", gaps, 0);
    chk("burst4_wc", {16'd0, word_cnt}, 32'd4);
    step();
    chk("burst4_rd_off", {31'd0, fifo_rd_en}, 32'd0);
    en = 1'b0;
    repeat (3) step();
    chk("burst4_idle", {31'd0, busy}, 32'd0);

    // Sink stalled: only two reads fit in the skid buffer.
    m_ready = 1'b0;
    load(3);
    n_rd = 0; en = 1'b1;
    repeat (6) step();
    chk("stall_reads", n_rd, 2);
    chk("stall_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1; n_xfer = 0;
    drain("stall", 20);
    chk("stall_xfers", n_xfer, 3);

    // Disable mid-burst: in-flight word still delivered, no new reads.
    en = 1'b0;
    repeat (3) step();
    load(8);
    n_rd = 0; n_xfer = 0; en = 1'b1;
    for (int i = 0; i < 10 && n_rd < 2; i++) step();
    en = 1'b0;
    step();
    rd_at_drain = n_rd;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!busy) break;
    end
    chk("drain_no_new_rd", n_rd, rd_at_drain);
    chk("drain_delivered", n_xfer, n_rd);
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_empty_at_idle", {31'd0, m_valid}, 32'd0);
    en = 1'b1;
    drain("drain_rest", 30);

    // Underflow on the first read: word dropped, sticky error, reads stop.
    en = 1'b0;
    repeat (3) step();
    load(4);
    inject_uf = 1'b1; en = 1'b1;
    for (int i = 0; i < 10 && !err; i++) step();
    chk("uf_err_set", {31'd0, err}, 32'd1);
    n_rd = 0;
    repeat (4) begin
      step();
      chk("uf_no_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("uf_busy", {31'd0, busy}, 32'd1);
    end
    chk("uf_reads", n_rd, 0);
    en = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("uf_clr_err", {31'd0, err}, 32'd0);
    chk("uf_clr_idle", {31'd0, busy}, 32'd0);
    en = 1'b1;
    drain("uf_rest", 30);

    // err_clr held across a fresh underflow: the underflow must win.
    en = 1'b0;
    repeat (3) step();
    load(3);
    inject_uf = 1'b1; err_clr = 1'b1; en = 1'b1;
    repeat (4) step();
    err_clr = 1'b0;
    drain("uf_clr_race", 30);

    // Reset with a full skid buffer discards it; streaming resumes afterwards.
    m_ready = 1'b0; en = 1'b1;
    load(6);
    repeat (5) step();
    chk("rst_occ2", exp_q.size(), 2);
    do_reset();
    m_ready = 1'b1;
    drain("post_rst", 30);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) load(1);
      en      = ($urandom_range(0, 9) != 0);
      m_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 59) == 0) inject_uf = 1'b1;
      err_clr = err_m && ($urandom_range(0, 3) == 0);
      step();
    end
    err_clr = 1'b1; en = 1'b0;
    step();
    err_clr = 1'b0; en = 1'b1; m_ready = 1'b1; inject_uf = 1'b0;
    drain("random", 60);

    // word_cnt wrap after 65535 + 1 transfers.
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) begin
      if (src_q.size() < 4) load(4);
      step();
    end
    chk("wc_max", {16'd0, word_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 5 && cnt_m != 16'd0; i++) step();
    chk("wc_wrap", {16'd0, word_cnt}, 32'd0);
    drain("final", 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: read enable from control; 0 requests a drain and stop.
REQ-005 The block SHALL have port err_clr, input, 1 bit: single-cycle pulse that clears the sticky error and leaves ERROR.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag, valid in the current cycle.
REQ-007 The block SHALL have port fifo_data_out, input, FIFO_WIDTH bits: FIFO read data, valid one cycle after fifo_rd_en.
REQ-008 The block SHALL have port fifo_underflow, input, 1 bit: FIFO underflow flag, asserted one cycle after a read of an empty FIFO.
REQ-009 The block SHALL have port fifo_rd_en, output, 1 bit: read strobe to the FIFO.
REQ-010 The block SHALL have port m_data, output, FIFO_WIDTH bits: stream data.
REQ-011 The block SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: sticky underflow error.
REQ-015 The block SHALL have port word_cnt, output, 16 bits: count of words accepted by the sink, wrapping.

Function
REQ-016 Read latency SHALL be fixed: the word for a fifo_rd_en issued in cycle N SHALL be captured from fifo_data_out at the end of cycle N+1, with fifo_underflow sampled in that same cycle.
REQ-017 Output buffering SHALL be a 2-entry FIFO-ordered skid buffer; m_data and m_valid SHALL come from registers, with no combinational path from fifo_data_out.
REQ-018 fifo_rd_en SHALL equal (state==RUN) && !fifo_empty && (occ + inflight - pop) < 2.
    - occ = skid occupancy (0..2).
    - inflight = 1 if fifo_rd_en was high in the previous cycle.
    - pop = m_valid && m_ready.
REQ-019 The sustained throughput SHALL be 1 word per cycle when the FIFO is non-empty and m_ready is held at 1.
REQ-020 Stream handshake: once m_valid=1, m_valid and m_data SHALL stay stable until m_ready=1; a transfer occurs on m_valid && m_ready.
REQ-021 word_cnt SHALL increment by 1 on each transfer and wrap from 16'hFFFF to 0.
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN and ERROR.
    - IDLE->RUN when en=1 and err=0.
    - RUN->DRAIN when en=0.
    - DRAIN->IDLE when inflight=0 and occ=0.
    - DRAIN->RUN when en=1 again.
    - Any state->ERROR when a captured read has fifo_underflow=1.
    - ERROR->IDLE on err_clr=1.
REQ-023 In DRAIN the block SHALL issue no new reads, SHALL still capture an in-flight word, and SHALL deliver all buffered words.
REQ-024 When a captured read has fifo_underflow=1, the word SHALL be discarded (not buffered), err SHALL be set, and the block SHALL enter ERROR.
REQ-025 In ERROR the block SHALL issue no reads; words already buffered SHALL still be delivered.
REQ-026 err SHALL clear only on err_clr or rst.
REQ-027 If err_clr and a new underflow occur in the same cycle, the underflow SHALL win and err SHALL stay 1.
REQ-028 A simultaneous capture and pop with occ=2 SHALL be impossible by REQ-018; a simultaneous capture and pop at occ=1 SHALL leave occ=1 with correct ordering.

Reset
REQ-029 On rst=1 the block SHALL asynchronously clear all state and outputs: state=IDLE, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, err=0, word_cnt=0, occ=0, inflight=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight and buffered words; the first cycle after release SHALL be IDLE.

Structure
REQ-031 The FSM state enum and the skid depth constant (2) SHALL live in shared package fifo_reader_pkg.
REQ-032 The 2-entry skid buffer SHALL be one sub-module, fifo_reader_skid, parameterised by FIFO_WIDTH.

Verification
REQ-033 Preload FIFO with 4 words 16'h0001..16'h0004, en=1, m_ready=1 -> the words appear on m_data in order on 4 consecutive cycles, word_cnt=4, then fifo_rd_en=0.
REQ-034 FIFO holds 3 words, m_ready=0 -> exactly 2 reads issued, m_valid=1 with m_data stable; m_ready=1 -> remaining word follows, no loss or duplicate.
REQ-035 Streaming with en dropped to 0 mid-burst after 2 reads -> DRAIN, the in-flight word is still delivered, busy falls only when occ=0, no further fifo_rd_en.
REQ-036 Force fifo_underflow=1 one cycle after a read -> word not delivered, err=1, state ERROR, fifo_rd_en stays 0; err_clr pulse -> IDLE, err=0.
REQ-037 Assert rst for 1 cycle with occ=2 -> m_valid=0, word_cnt=0 immediately; after release, with en=1, streaming resumes from the next FIFO word.
REQ-038 Preset word_cnt via 65535 transfers, then 1 more transfer -> word_cnt=0.
